// File: rtl/hd44780_responder.sv
// HD44780-style LCD bus responder: decodes E-strobed writes into a mirrored 2x40 DDRAM,
// address counter and display-control flags, with a readback port for the mirror.
module hd44780_responder #(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic       rd_line,
    input  logic [5:0] rd_col,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       wr_strobe,
    output logic       cmd_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam logic [6:0] LAST_IDX = 7'd79;

    // Step the address counter, wrapping line 0 col 39 <-> line 1 col 0 and line 1 col 39 <-> 0
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [6:0] cell_index(input logic line, input logic [5:0] col);
        logic [6:0] r;
        if (line) r = 7'd40 + {1'b0, col};
        else      r = {1'b0, col};
        return r;
    endfunction

    logic [7:0] ddram [0:79];

    logic       e_q_r;
    logic       rs_r;
    logic       rw_r;
    logic [7:0] data_r;
    state_t     state_r, state_nxt;
    logic [6:0] fill_idx_r, fill_idx_nxt;
    logic [6:0] ac_r, ac_nxt;
    logic       display_on_r, display_on_nxt;
    logic       cursor_on_r, cursor_on_nxt;
    logic       blink_on_r, blink_on_nxt;
    logic       entry_inc_r, entry_inc_nxt;
    logic       ddram_mode_r, ddram_mode_nxt;
    logic       wr_strobe_r, wr_strobe_nxt;
    logic       cmd_err_r, cmd_err_nxt;
    logic [7:0] rd_char_r;

    logic       exec_s;
    logic       mem_we_s;
    logic [6:0] mem_addr_s;
    logic [7:0] mem_wdata_s;
    logic [6:0] rd_idx_s;

    assign exec_s   = e_q_r & ~lcd_e;
    assign rd_idx_s = cell_index(rd_line, rd_col);

    // Bus capture: hold the last rs/rw/data seen while E was high
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_q_r  <= 1'b0;
            rs_r   <= 1'b0;
            rw_r   <= 1'b0;
            data_r <= 8'h00;
        end else begin
            e_q_r <= lcd_e;
            if (lcd_e) begin
                rs_r   <= lcd_rs;
                rw_r   <= lcd_rw;
                data_r <= lcd_data;
            end
        end
    end

    // Fill sequencing, transaction decode and DDRAM write-port selection
    always_comb begin
        state_nxt      = state_r;
        fill_idx_nxt   = fill_idx_r;
        ac_nxt         = ac_r;
        display_on_nxt = display_on_r;
        cursor_on_nxt  = cursor_on_r;
        blink_on_nxt   = blink_on_r;
        entry_inc_nxt  = entry_inc_r;
        ddram_mode_nxt = ddram_mode_r;
        wr_strobe_nxt  = 1'b0;
        cmd_err_nxt    = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_s     = fill_idx_r;
        mem_wdata_s    = FILL_CHAR;

        case (state_r)
            ST_FILL: begin
                mem_we_s = 1'b1;
                if (fill_idx_r == LAST_IDX) begin
                    state_nxt    = ST_IDLE;
                    fill_idx_nxt = 7'd0;
                end else begin
                    fill_idx_nxt = fill_idx_r + 7'd1;
                end
            end
            ST_IDLE: begin
                fill_idx_nxt = 7'd0;
            end
            default: begin
                state_nxt    = ST_FILL;
                fill_idx_nxt = 7'd0;
            end
        endcase

        if (exec_s) begin
            if (rw_r || (state_r == ST_FILL)) begin
                cmd_err_nxt = 1'b1;
            end else if (rs_r) begin
                // In CGRAM mode data bytes are swallowed without touching AC
                if (ddram_mode_r) begin
                    mem_we_s      = 1'b1;
                    mem_addr_s    = cell_index(ac_r[6], ac_r[5:0]);
                    mem_wdata_s   = data_r;
                    wr_strobe_nxt = 1'b1;
                    ac_nxt        = ac_step(ac_r, entry_inc_r);
                end else begin
                    ac_nxt = ac_r;
                end
            end else begin
                casez (data_r)
                    8'b1???????: begin
                        if (data_r[5:0] <= 6'd39) begin
                            ac_nxt         = data_r[6:0];
                            ddram_mode_nxt = 1'b1;
                        end else begin
                            cmd_err_nxt = 1'b1;
                        end
                    end
                    8'b01??????: ddram_mode_nxt = 1'b0;
                    8'b001?????: ac_nxt = ac_r;
                    8'b0001????: begin
                        if (!data_r[3]) begin
                            ac_nxt = ac_step(ac_r, data_r[2]);
                        end else begin
                            ac_nxt = ac_r;
                        end
                    end
                    8'b00001???: begin
                        display_on_nxt = data_r[2];
                        cursor_on_nxt  = data_r[1];
                        blink_on_nxt   = data_r[0];
                    end
                    8'b000001??: entry_inc_nxt = data_r[1];
                    // Home and clear both point AC back into DDRAM space
                    8'b0000001?: begin
                        ac_nxt         = 7'h00;
                        ddram_mode_nxt = 1'b1;
                    end
                    8'b00000001: begin
                        ac_nxt         = 7'h00;
                        entry_inc_nxt  = 1'b1;
                        ddram_mode_nxt = 1'b1;
                        state_nxt      = ST_FILL;
                        fill_idx_nxt   = 7'd0;
                    end
                    default: cmd_err_nxt = 1'b1;
                endcase
            end
        end else begin
            cmd_err_nxt = 1'b0;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_FILL;
            fill_idx_r   <= 7'd0;
            ac_r         <= 7'h00;
            display_on_r <= 1'b0;
            cursor_on_r  <= 1'b0;
            blink_on_r   <= 1'b0;
            entry_inc_r  <= 1'b1;
            ddram_mode_r <= 1'b1;
            wr_strobe_r  <= 1'b0;
            cmd_err_r    <= 1'b0;
            rd_char_r    <= 8'h00;
        end else begin
            state_r      <= state_nxt;
            fill_idx_r   <= fill_idx_nxt;
            ac_r         <= ac_nxt;
            display_on_r <= display_on_nxt;
            cursor_on_r  <= cursor_on_nxt;
            blink_on_r   <= blink_on_nxt;
            entry_inc_r  <= entry_inc_nxt;
            ddram_mode_r <= ddram_mode_nxt;
            wr_strobe_r  <= wr_strobe_nxt;
            cmd_err_r    <= cmd_err_nxt;
            rd_char_r    <= (rd_col > 6'd39) ? FILL_CHAR : ddram[rd_idx_s];
        end
    end

    // DDRAM storage; contents are established by the fill that follows every reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            ddram[mem_addr_s] <= mem_wdata_s;
        end
    end

    assign rd_char    = rd_char_r;
    assign ac         = ac_r;
    assign display_on = display_on_r;
    assign cursor_on  = cursor_on_r;
    assign blink_on   = blink_on_r;
    assign entry_inc  = entry_inc_r;
    assign busy       = (state_r == ST_FILL);
    assign wr_strobe  = wr_strobe_r;
    assign cmd_err    = cmd_err_r;

endmodule

// File: tb/tb_hd44780_responder.sv
// Bench for hd44780_responder: directed vector table, hand-written timing sequences,
// then random bus traffic against a line/column reference model.
module tb_hd44780_responder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic       rd_line = 1'b0;
    logic [5:0] rd_col = 6'd0;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       display_on, cursor_on, blink_on, entry_inc, busy, wr_strobe, cmd_err;

    hd44780_responder #(.FILL_CHAR(8'h20)) dut (
        .clk(clk), .resetn(resetn), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data), .rd_line(rd_line), .rd_col(rd_col), .rd_char(rd_char),
        .ac(ac), .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .busy(busy), .wr_strobe(wr_strobe), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (cmd_err) err_cnt++;
        if (busy && resetn) busy_cnt++;
    end

    // reference model: cursor as (line, column), DDRAM as flat 80-entry array
    int         m_line, m_col;
    bit         m_disp, m_cur, m_blink, m_inc, m_ddram;
    logic [7:0] mem_m [0:79];

    typedef struct {
        bit         rs;
        bit         rw;
        logic [7:0] d;
        logic [6:0] eac;
        logic [3:0] eflags;
        int         ewr;
        int         eerr;
    } vec_t;
    vec_t vecs[$];

    int dw, de, n, kind, line_v, col_v;
    bit rs_v, rw_v, ew, ee, ec;
    logic [7:0] d_v;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic addv(input bit rs, input bit rw, input logic [7:0] d, input logic [6:0] eac,
                        input logic [3:0] ef, input int ewr, input int eerr);
        vec_t v;
        v.rs = rs; v.rw = rw; v.d = d; v.eac = eac; v.eflags = ef; v.ewr = ewr; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    // one E pulse (high two clocks), bus garbled after E falls; returns pulse counts
    task automatic xfer(input bit rs, input bit rw, input logic [7:0] d, output int pw, output int pe);
        int w0, e0;
        @(negedge clk); #1;
        w0 = wr_cnt; e0 = err_cnt;
        lcd_e = 1'b1; lcd_rs = rs; lcd_rw = rw; lcd_data = d;
        @(negedge clk);
        @(negedge clk); #1;
        lcd_e = 1'b0; lcd_rs = ~rs; lcd_rw = ~rw; lcd_data = ~d;
        @(negedge clk);
        @(negedge clk); #1;
        pw = wr_cnt - w0;
        pe = err_cnt - e0;
    endtask

    task automatic rd_check(input string name, input int line, input int col, input int exp);
        @(negedge clk); #1;
        rd_line = line[0]; rd_col = col[5:0];
        @(negedge clk);
        chk(name, rd_char, exp);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic release_and_fill(input string name);
        int k = 0;
        #1 resetn = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 300);
        chk(name, k, 80);
    endtask

    task automatic model_reset();
        m_line = 0; m_col = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1; m_ddram = 1;
        for (int i = 0; i < 80; i++) mem_m[i] = 8'h20;
    endtask

    task automatic model_step(input bit up);
        if (up) begin
            m_col++;
            if (m_col == 40) begin m_col = 0; m_line = 1 - m_line; end
        end else begin
            m_col--;
            if (m_col < 0) begin m_col = 39; m_line = 1 - m_line; end
        end
    endtask

    task automatic model_apply(input bit rs, input bit rw, input logic [7:0] d,
                               output bit pw, output bit pe, output bit pc);
        int msb = -1;
        pw = 0; pe = 0; pc = 0;
        if (rw) begin
            pe = 1;
        end else if (rs) begin
            if (m_ddram) begin
                mem_m[m_line * 40 + m_col] = d;
                pw = 1;
                model_step(m_inc);
            end
        end else begin
            for (int b = 7; b >= 0; b--) if (msb < 0 && d[b]) msb = b;
            case (msb)
                7: if (int'(d[5:0]) < 40) begin m_line = d[6]; m_col = d[5:0]; m_ddram = 1; end
                   else pe = 1;
                6: m_ddram = 0;
                5: ;
                4: if (!d[3]) model_step(d[2]);
                3: begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
                2: m_inc = d[1];
                1: begin m_line = 0; m_col = 0; m_ddram = 1; end
                0: begin
                    m_line = 0; m_col = 0; m_inc = 1; m_ddram = 1; pc = 1;
                    for (int i = 0; i < 80; i++) mem_m[i] = 8'h20;
                end
                default: pe = 1;
            endcase
        end
    endtask

    initial begin
        // directed vectors: {rs, rw, data, ac, {disp,cur,blink,inc}, wr pulses, err pulses}
        addv(0,0,8'h0C,7'h00,4'b1001,0,0); addv(0,0,8'h06,7'h00,4'b1001,0,0);
        addv(0,0,8'h80,7'h00,4'b1001,0,0); addv(1,0,8'h32,7'h01,4'b1001,1,0);
        addv(1,0,8'h30,7'h02,4'b1001,1,0); addv(1,0,8'h32,7'h03,4'b1001,1,0);
        addv(1,0,8'h34,7'h04,4'b1001,1,0); addv(0,0,8'hA7,7'h27,4'b1001,0,0);
        addv(1,0,8'h41,7'h40,4'b1001,1,0); addv(0,0,8'hE7,7'h67,4'b1001,0,0);
        addv(1,0,8'h42,7'h00,4'b1001,1,0); addv(0,0,8'h04,7'h00,4'b1000,0,0);
        addv(0,0,8'h80,7'h00,4'b1000,0,0); addv(1,0,8'h5A,7'h67,4'b1000,1,0);
        addv(0,0,8'hA8,7'h67,4'b1000,0,1); addv(0,1,8'h80,7'h67,4'b1000,0,1);
        addv(0,0,8'h0F,7'h67,4'b1110,0,0); addv(0,0,8'h14,7'h00,4'b1110,0,0);
        addv(0,0,8'h10,7'h67,4'b1110,0,0); addv(0,0,8'h18,7'h67,4'b1110,0,0);
        addv(0,0,8'h3F,7'h67,4'b1110,0,0); addv(0,0,8'h02,7'h00,4'b1110,0,0);
        addv(0,0,8'h40,7'h00,4'b1110,0,0); addv(1,0,8'h55,7'h00,4'b1110,0,0);
        addv(0,0,8'h00,7'h00,4'b1110,0,1); addv(0,0,8'h08,7'h00,4'b0000,0,0);
        addv(0,0,8'h06,7'h00,4'b0001,0,0); addv(0,0,8'h85,7'h05,4'b0001,0,0);
        addv(1,0,8'h58,7'h06,4'b0001,1,0);

        // reset state and post-reset fill
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_ac", ac, 0);
        chk("rst_flags", {display_on, cursor_on, blink_on, entry_inc}, 4'b0001);
        chk("rst_pulses", {wr_strobe, cmd_err}, 0);
        chk("rst_rd_char", rd_char, 0);
        release_and_fill("post_reset_fill_len");
        for (int i = 0; i < 80; i++) rd_check("post_reset_cell", i / 40, i % 40, 8'h20);

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].rs, vecs[i].rw, vecs[i].d, dw, de);
            chk($sformatf("vec%0d_ac", i), ac, vecs[i].eac);
            chk($sformatf("vec%0d_flags", i), {display_on, cursor_on, blink_on, entry_inc}, vecs[i].eflags);
            chk($sformatf("vec%0d_wr", i), dw, vecs[i].ewr);
            chk($sformatf("vec%0d_err", i), de, vecs[i].eerr);
            if (i == 6) begin
                rd_check("rb_2024_0", 0, 0, 8'h32); rd_check("rb_2024_1", 0, 1, 8'h30);
                rd_check("rb_2024_2", 0, 2, 8'h32); rd_check("rb_2024_3", 0, 3, 8'h34);
            end
        end
        rd_check("rb_dec_wrap", 0, 0, 8'h5A);
        rd_check("rb_fwd_wrap0", 0, 39, 8'h41);
        rd_check("rb_fwd_wrap1", 1, 39, 8'h42);
        rd_check("rb_addr85", 0, 5, 8'h58);
        rd_check("rb_blank", 1, 0, 8'h20);
        rd_check("rb_col_oob", 1, 45, 8'h20);

        // clear, then read the cell being filled in the same cycle it is written
        xfer(0, 0, 8'h01, dw, de);
        chk("clear_busy", busy, 1);
        repeat (4) @(negedge clk);
        #1 rd_line = 1'b0; rd_col = 6'd5;
        @(negedge clk);
        chk("overlap_old", rd_char, 8'h58);
        @(negedge clk);
        chk("overlap_new", rd_char, 8'h20);
        wait_idle();

        // transaction during fill is dropped; busy stays high 80 cycles
        busy_cnt = 0;
        xfer(0, 0, 8'h01, dw, de);
        repeat (5) @(negedge clk);
        xfer(1, 0, 8'h77, dw, de);
        chk("busy_drop_err", de, 1);
        chk("busy_drop_wr", dw, 0);
        chk("busy_drop_ac", ac, 0);
        wait_idle();
        chk("clear_busy_len", busy_cnt, 80);
        rd_check("busy_drop_cell", 0, 0, 8'h20);

        // reset mid-fill restarts the fill from index 0
        xfer(0, 0, 8'h01, dw, de);
        repeat (20) @(negedge clk);
        #1 resetn = 1'b0;
        #1 chk("midfill_busy", busy, 1);
        @(negedge clk);
        release_and_fill("midfill_refill_len");

        // reset while wr_strobe is high kills the pulse immediately
        @(negedge clk); #1;
        lcd_e = 1'b1; lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h61;
        @(negedge clk);
        @(negedge clk); #1;
        lcd_e = 1'b0; lcd_rs = 1'b0;
        @(negedge clk); #1;
        chk("strobe_pre", wr_strobe, 1);
        chk("strobe_pre_ac", ac, 1);
        resetn = 1'b0;
        #1;
        chk("strobe_killed", wr_strobe, 0);
        chk("strobe_rst_ac", ac, 0);
        @(negedge clk);
        release_and_fill("midstrobe_refill_len");
        rd_check("midstrobe_cell", 0, 0, 8'h20);

        // random traffic against the model
        model_reset();
        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 9);
            rs_v = 0; rw_v = 0; d_v = 8'h00;
            case (kind)
                0, 1, 2, 3: begin rs_v = 1; d_v = 8'($urandom_range(0, 255)); end
                4: begin
                    line_v = $urandom_range(0, 1); col_v = $urandom_range(0, 47);
                    d_v = 8'h80 | 8'(line_v * 64) | 8'(col_v);
                end
                5: d_v = 8'($urandom_range(0, 255));
                6: d_v = 8'h10 | 8'($urandom_range(0, 15));
                7: d_v = ($urandom_range(0, 1) == 1) ? (8'h04 | 8'($urandom_range(0, 3)))
                                                    : (8'h08 | 8'($urandom_range(0, 7)));
                8: case ($urandom_range(0, 3))
                       0: d_v = 8'h40 | 8'($urandom_range(0, 63));
                       1: d_v = 8'h02;
                       2: d_v = 8'h01;
                       default: d_v = 8'h80;
                   endcase
                default: begin rw_v = 1; rs_v = 1'($urandom_range(0, 1)); d_v = 8'($urandom_range(0, 255)); end
            endcase
            model_apply(rs_v, rw_v, d_v, ew, ee, ec);
            xfer(rs_v, rw_v, d_v, dw, de);
            chk($sformatf("rnd%0d_ac", it), ac, m_line * 64 + m_col);
            chk($sformatf("rnd%0d_flags", it), {display_on, cursor_on, blink_on, entry_inc},
                {m_disp, m_cur, m_blink, m_inc});
            chk($sformatf("rnd%0d_wr", it), dw, ew);
            chk($sformatf("rnd%0d_err", it), de, ee);
            chk($sformatf("rnd%0d_busy", it), busy, ec);
            if (ec) wait_idle();
            if (it % 10 == 0) begin
                line_v = $urandom_range(0, 1); col_v = $urandom_range(0, 63);
                rd_check("rnd_read", line_v, col_v, (col_v > 39) ? 8'h20 : mem_m[line_v * 40 + col_v]);
            end
        end
        for (int i = 0; i < 80; i++) rd_check("final_cell", i / 40, i % 40, mem_m[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hd44780_responder.md
HD44780_RESPONDER -- requirements
Module: hd44780_responder

Interface
REQ-001 Parameter: FILL_CHAR, 8'h20, character written to every DDRAM cell by clear and post-reset fill.
REQ-002 Port: clk  in  1  system clock; all state updates on its rising edge.
REQ-003 Port: resetn  in  1  asynchronous, active-low reset.
REQ-004 Port: lcd_e  in  1  LCD enable strobe; transaction latched on its falling edge.
REQ-005 Port: lcd_rs  in  1  0 = command, 1 = data.
REQ-006 Port: lcd_rw  in  1  0 = write; 1 = read, not supported.
REQ-007 Port: lcd_data  in  8  command or character byte.
REQ-008 Port: rd_line  in  1  display-mirror read line select.
REQ-009 Port: rd_col  in  6  display-mirror read column, 0-39.
REQ-010 Port: rd_char  out  8  DDRAM content at (rd_line, rd_col), registered.
REQ-011 Port: ac  out  7  address counter, HD44780 DDRAM address format.
REQ-012 Port: display_on, cursor_on, blink_on  out  1 each  display-control flags.
REQ-013 Port: entry_inc  out  1  entry-mode I/D flag.
REQ-014 Port: busy  out  1  high while a DDRAM fill is in progress.
REQ-015 Port: wr_strobe  out  1  one-cycle pulse per accepted DDRAM data write.
REQ-016 Port: cmd_err  out  1  one-cycle pulse per dropped or illegal transaction.

Function
REQ-017 Latching: lcd_rs/lcd_rw/lcd_data registered every cycle lcd_e=1; lcd_e registered as e_q.
REQ-018 Falling edge: detected in a cycle with e_q=1 and lcd_e=0; transaction executes on that rising edge using the last values captured while lcd_e=1.
REQ-019 Storage: 80x8 DDRAM; index = line*40 + col; line = ac[6], col = ac[5:0].
REQ-020 Dropped transactions: lcd_rw=1 or busy=1 -> no state change, cmd_err pulses.
REQ-021 Command precedence: highest set bit of lcd_data selects the command.
REQ-022 Clear (0x01): AC=0, entry_inc=1, busy=1, then FILL_CHAR written to indices 0..79, one per clock; busy falls the cycle after index 79 is written (80 busy cycles).
REQ-023 Return home (0x02/0x03): AC=0; DDRAM unchanged.
REQ-024 Entry mode (0b000001_I_S): entry_inc=I; S stored and has no display effect.
REQ-025 Display control (0b00001_D_C_B): display_on=D, cursor_on=C, blink_on=B.
REQ-026 Cursor/display shift (0b0001_SC_RL_xx): SC=0 moves AC by one (RL=1 +1, RL=0 -1) with REQ-031 wrap; SC=1 no effect.
REQ-027 Function set (0b001xxxxx): accepted, no effect.
REQ-028 CGRAM address (0b01xxxxxx): enters CGRAM mode; subsequent data writes are discarded without changing AC and without pulsing wr_strobe.
REQ-029 DDRAM address (0b1aaaaaaa): col a[5:0]<=39 -> AC=a[6:0] and DDRAM mode; col>39 -> AC unchanged and cmd_err pulse.
REQ-030 Data write (rs=1, DDRAM mode): DDRAM[AC]=data, wr_strobe pulses, AC steps per entry_inc.
REQ-031 AC wrap: +1 takes 0x27->0x40 and 0x67->0x00; -1 takes 0x00->0x67 and 0x40->0x27.
REQ-032 Read port: rd_char = DDRAM at (rd_line, rd_col) one clock after the address is presented; rd_col>39 returns FILL_CHAR; the read port is independent of busy.
REQ-033 Simultaneous events: a fill write and a read of the same cell in the same cycle return the old content.

Reset
REQ-034 Reset values: ac=0, display_on=0, cursor_on=0, blink_on=0, entry_inc=1, wr_strobe=0, cmd_err=0, rd_char=0, DDRAM mode, e_q=0.
REQ-035 Busy at reset: busy=1 during reset; the fill of REQ-022 starts at the first clock after resetn deasserts.
REQ-036 Reset mid-operation: assertion mid-fill or mid-strobe aborts the operation immediately; the fill restarts from index 0 after release.

Verification
REQ-037 Post-reset fill: release reset, then wait 80 clocks -> busy falls; all 80 rd_char reads = 8'h20.
REQ-038 Write and read back: after fill, send 0x0C, 0x06, 0x80, data "2024" -> display_on=1, ac=0x04, 4 wr_strobe pulses; rd (0,0..3) = 8'h32,8'h30,8'h32,8'h34.
REQ-039 Forward line wrap: cmd 0xA7, data 8'h41 -> ac=0x40, (0,39)=8'h41; then cmd 0xE7, data 8'h42 -> ac=0x00, (1,39)=8'h42.
REQ-040 Decrement wrap: cmd 0x04, cmd 0x80, data 8'h5A -> ac=0x67, (0,0)=8'h5A.
REQ-041 Dropped transactions: issue cmd 0x01, then an E pulse 10 clocks later -> cmd_err pulses, no DDRAM/AC change, busy high for 80 clocks; an rw=1 pulse -> cmd_err pulse.
REQ-042 Illegal address and CGRAM mode: cmd 0xA8 -> cmd_err, AC unchanged; cmd 0x40 then data 8'h55 -> no wr_strobe, DDRAM unchanged.
